ex_muldiv_unsigned: RTL and testbench
=====================================

// Module: ex_muldiv_unsigned
// PURPOSE
// - Parametrised, multi-cycle unsigned multiply/divide unit hanging off stg_ex; covers MULU/DIVU/REMU, which the single-cycle ALU cannot.
// - Radix-2 iterative datapath, one bit per cycle; start/done handshake; while ow_busy=1 stg_ex holds the pipe via iw_stall.
// - Drives a result, a GP target tag and a 4-bit flag nibble that stg_ex merges into SR[FL].
// PARAMETERS
// - DATA_W  24                 operand/result width (>=4)
// - CNT_W   $clog2(DATA_W+1)   iteration counter width
// - TGT_W   4                  GP target-tag width (passed through)
// PORTS
// - iw_clk        in   1        clock; single clock domain
// - iw_rst        in   1        reset, asynchronous, active-high
// - iw_start      in   1        request; accepted on a rising edge where iw_start && !ow_busy && !iw_flush
// - iw_op         in   2        MULU_LO / MULU_HI / DIVU / REMU (encodings from src/muldiv.vh)
// - iw_src        in   DATA_W   multiplier / divisor
// - iw_tgt        in   DATA_W   multiplicand / dividend
// - iw_tgt_gp     in   TGT_W    destination register tag
// - iw_flush      in   1        abort in-flight operation
// - ow_busy       out  1        1 in RUN state only
// - ow_done       out  1        one-cycle completion pulse
// - ow_result     out  DATA_W   result; held from done until the next accept
// - ow_flags      out  4        {V,C,N,Z}: bit0 Z, bit1 N, bit2 C, bit3 V
// - ow_tgt_gp     out  TGT_W    tag captured at accept, held with result
// BEHAVIOUR
// - Reset (async): state IDLE, ow_busy=0, ow_done=0, ow_result=0, ow_flags=0, ow_tgt_gp=0, counter=0.
// - FSM IDLE/RUN/DONE. Accept -> RUN, cnt=DATA_W. Each RUN edge runs one step and decrements cnt; the step at cnt==1 -> DONE.
// - Latency: ow_done visible DATA_W cycles after the accept edge (24 by default). DONE lasts exactly 1 cycle, then IDLE.
// - ow_busy=0 in DONE, so a start may be accepted in the DONE cycle (back-to-back -> RUN). Start while busy is ignored; there is no queue.
// - MUL: 2*DATA_W-bit product. MULU_LO returns the low half; C=1 iff the high half is nonzero. MULU_HI returns the high half; C=0.
// - DIV: restoring division. DIVU returns the quotient; REMU returns the remainder. C=0.
// - Divide by zero: detected at accept; goes straight to DONE (done 1 cycle after accept).
//   Quotient = all-ones, remainder = dividend, V=1. V=0 for every other case.
// - Z=(result==0); N=result[DATA_W-1]; flags are valid with ow_done and held with the result.
// - Flush: priority over start in the same cycle. RUN -> IDLE next edge; no done pulse; result, flags and tag keep their previous values.
//   Flush in IDLE: no effect. Flush in the DONE cycle: the done pulse has already been issued; next state IDLE.
// - Reset mid-operation: immediate return to reset values; the operation is lost.
// - Operand registers are captured at accept. Input changes during RUN are ignored.
// CONFIGURATION
// - MULDIV_DIV_EN defined: DIVU/REMU implemented as above.
// - MULDIV_DIV_EN undefined: divide datapath not built. DIVU/REMU are illegal:
//   they go straight to DONE (1 cycle) with result=0, Z=1, V=1, and ow_busy is never asserted for them.
// STRUCTURE
// - src/muldiv.vh: op encodings (MULDIV_OP_MULU_LO=0, _MULU_HI=1, _DIVU=2, _REMU=3).
// - src/flags.vh: flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
// - Sub-module muldiv_step (combinational): one shift-add or shift-subtract iteration on {acc, q}, parametrised by DATA_W.
//   This top level holds the FSM, counter, operand/tag registers and flag generation.
// TESTING (DATA_W=24)
// - MULU_LO 0x001000*0x000100 -> done 24 cycles after accept; result 0x100000, Z=0, C=0, tag echoed.
// - MULU_LO then MULU_HI 0xFFFFFF*0xFFFFFF -> 0x000001 with C=1; then 0xFFFFFE with N=1, C=0.
// - DIVU 0x000064/0x000007 -> 0x00000E; REMU same operands -> 0x000002; V=0.
// - DIVU 0x123456/0 -> done 1 cycle after accept, result 0xFFFFFF, V=1, N=1. REMU -> 0x123456.
//   With MULDIV_DIV_EN undefined: result 0, Z=1, V=1.
// - Flush 5 cycles into a MULU -> busy low next cycle, no done, old result held.
//   A new start issued in the next cycle completes correctly. Start during RUN is ignored.
// - Back-to-back: start held across the DONE cycle -> second op accepted in DONE, done again 24 cycles later.
//   Async reset mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unsigned_pkg.sv
// Shared types for the multi-cycle unsigned multiply/divide unit: op codes, FSM states and
// flag bit positions inside the {V,C,N,Z} nibble.
package ex_muldiv_unsigned_pkg;

    typedef enum logic [1:0] {
        OpMuluLo = 2'd0,
        OpMuluHi = 2'd1,
        OpDivu   = 2'd2,
        OpRemu   = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagC = 2;
    localparam int unsigned FlagV = 3;

    function automatic logic is_div(muldiv_op_e op);
        return (op == OpDivu) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/ex_muldiv_unsigned_if.sv
// Request/response bundle between stg_ex (master) and the multiply/divide unit (slave).
interface ex_muldiv_unsigned_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned TGT_W  = 4
);
    logic              iw_start;
    logic [1:0]        iw_op;
    logic [DATA_W-1:0] iw_src;
    logic [DATA_W-1:0] iw_tgt;
    logic [TGT_W-1:0]  iw_tgt_gp;
    logic              iw_flush;
    logic              ow_busy;
    logic              ow_done;
    logic [DATA_W-1:0] ow_result;
    logic [3:0]        ow_flags;
    logic [TGT_W-1:0]  ow_tgt_gp;

    modport master (
        output iw_start, iw_op, iw_src, iw_tgt, iw_tgt_gp, iw_flush,
        input  ow_busy, ow_done, ow_result, ow_flags, ow_tgt_gp
    );

    modport slave (
        input  iw_start, iw_op, iw_src, iw_tgt, iw_tgt_gp, iw_flush,
        output ow_busy, ow_done, ow_result, ow_flags, ow_tgt_gp
    );
endinterface

// File: rtl/ex_muldiv_unsigned_step.sv
// One radix-2 iteration on {acc, q}: shift-add for multiply, restoring shift-subtract for
// divide. The divide path exists only when MULDIV_DIV_EN is defined.
module ex_muldiv_unsigned_step #(
    parameter int unsigned DATA_W = 24
) (
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_q,
    input  logic [DATA_W-1:0] i_b,
`ifdef MULDIV_DIV_EN
    input  logic              i_div,
`endif
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W:0] w_add;

    // Multiply: q holds the multiplier, its LSB selects the add, the pair shifts right.
    assign w_add = i_q[0] ? ({1'b0, i_acc} + {1'b0, i_b}) : {1'b0, i_acc};

`ifdef MULDIV_DIV_EN
    logic [DATA_W:0]   w_shl;
    logic [DATA_W-1:0] w_sub;

    assign w_shl = {i_acc, i_q[DATA_W-1]};
    // Only used when w_shl >= i_b, so the true difference always fits in DATA_W bits.
    assign w_sub = w_shl[DATA_W-1:0] - i_b;

    always_comb begin
        o_acc = w_add[DATA_W:1];
        o_q   = {w_add[0], i_q[DATA_W-1:1]};
        if (i_div) begin
            if (w_shl >= {1'b0, i_b}) begin
                o_acc = w_sub;
                o_q   = {i_q[DATA_W-2:0], 1'b1};
            end else begin
                o_acc = w_shl[DATA_W-1:0];
                o_q   = {i_q[DATA_W-2:0], 1'b0};
            end
        end
    end
`else
    assign o_acc = w_add[DATA_W:1];
    assign o_q   = {w_add[0], i_q[DATA_W-1:1]};
`endif

endmodule

// File: rtl/ex_muldiv_unsigned.sv
// Multi-cycle unsigned MULU_LO/MULU_HI/DIVU/REMU unit with start/done handshake.
// Build option MULDIV_DIV_EN enables the divider; without it DIVU/REMU complete as illegal ops.
module ex_muldiv_unsigned
    import ex_muldiv_unsigned_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1),
    parameter int unsigned TGT_W  = 4
) (
    input logic                 iw_clk,
    input logic                 iw_rst,
    ex_muldiv_unsigned_if.slave bus
);
    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    muldiv_op_e        r_op;
    logic [DATA_W-1:0] r_acc, r_q, r_b;
    logic [TGT_W-1:0]  r_tgt, r_tgt_out;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;

    muldiv_op_e        w_in_op;
    logic              w_in_div, w_accept, w_fast, w_last, w_c, w_v;
    logic [DATA_W-1:0] w_acc_nxt, w_q_nxt, w_res;
    logic [3:0]        w_flags;

    assign w_in_op  = muldiv_op_e'(bus.iw_op);
    assign w_in_div = is_div(w_in_op);
    assign w_accept = bus.iw_start && (r_state != StRun) && !bus.iw_flush;
    assign w_last   = (r_state == StRun) && (r_cnt == CNT_W'(1));
`ifdef MULDIV_DIV_EN
    assign w_fast   = w_in_div && (bus.iw_src == '0);
`else
    assign w_fast   = w_in_div;
`endif

`ifdef MULDIV_DIV_EN
    logic w_run_div;
    assign w_run_div = is_div(r_op);
`endif

    ex_muldiv_unsigned_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .i_acc(r_acc),
        .i_q  (r_q),
        .i_b  (r_b),
`ifdef MULDIV_DIV_EN
        .i_div(w_run_div),
`endif
        .o_acc(w_acc_nxt),
        .o_q  (w_q_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun: begin
                if (bus.iw_flush) w_state_nxt = StIdle;
                else if (r_cnt == CNT_W'(1)) w_state_nxt = StDone;
            end
            default: begin
                if (w_accept) w_state_nxt = w_fast ? StDone : StRun;
                else w_state_nxt = StIdle;
            end
        endcase
    end

    // In RUN this is the final-step result; otherwise the immediate divide-by-zero/illegal result.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        if (r_state == StRun) begin
            unique case (r_op)
                OpMuluLo: begin
                    w_res = w_q_nxt;
                    w_c   = |w_acc_nxt;
                end
                OpMuluHi: w_res = w_acc_nxt;
                OpDivu:   w_res = w_q_nxt;
                OpRemu:   w_res = w_acc_nxt;
            endcase
        end else begin
            w_v = 1'b1;
`ifdef MULDIV_DIV_EN
            w_res = (w_in_op == OpDivu) ? '1 : bus.iw_tgt;
`endif
        end
        w_flags        = '0;
        w_flags[FlagZ] = (w_res == '0);
        w_flags[FlagN] = w_res[DATA_W-1];
        w_flags[FlagC] = w_c;
        w_flags[FlagV] = w_v;
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_op      <= OpMuluLo;
            r_acc     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_tgt     <= '0;
            r_tgt_out <= '0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= w_in_op;
                r_tgt <= bus.iw_tgt_gp;
                r_cnt <= CNT_W'(DATA_W);
                r_acc <= '0;
                r_q   <= w_in_div ? bus.iw_tgt : bus.iw_src;
                r_b   <= w_in_div ? bus.iw_src : bus.iw_tgt;
                if (w_fast) begin
                    r_result  <= w_res;
                    r_flags   <= w_flags;
                    r_tgt_out <= bus.iw_tgt_gp;
                end
            end else if ((r_state == StRun) && !bus.iw_flush) begin
                r_acc <= w_acc_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_result  <= w_res;
                    r_flags   <= w_flags;
                    r_tgt_out <= r_tgt;
                end
            end
        end
    end

    assign bus.ow_busy   = (r_state == StRun);
    assign bus.ow_done   = (r_state == StDone);
    assign bus.ow_result = r_result;
    assign bus.ow_flags  = r_flags;
    assign bus.ow_tgt_gp = r_tgt_out;

endmodule

// File: tb/tb_ex_muldiv_unsigned.sv
// Bench for ex_muldiv_unsigned: arithmetic reference model plus directed and random stimulus.
module tb_ex_muldiv_unsigned;
    localparam int unsigned DW = 24;
    localparam int unsigned TW = 4;

`ifdef MULDIV_DIV_EN
    localparam int          DIV_LAT  = 24;
    localparam logic [23:0] DIVU_RES = 24'h00000E;
    localparam logic [3:0]  DIVU_FL  = 4'b0000;
    localparam logic [23:0] REMU_RES = 24'h000002;
    localparam logic [3:0]  REMU_FL  = 4'b0000;
    localparam logic [23:0] DZQ_RES  = 24'hFFFFFF;
    localparam logic [3:0]  DZQ_FL   = 4'b1010;
    localparam logic [23:0] DZR_RES  = 24'h123456;
    localparam logic [3:0]  DZR_FL   = 4'b1000;
`else
    localparam int          DIV_LAT  = 0;
    localparam logic [23:0] DIVU_RES = 24'h000000;
    localparam logic [3:0]  DIVU_FL  = 4'b1001;
    localparam logic [23:0] REMU_RES = 24'h000000;
    localparam logic [3:0]  REMU_FL  = 4'b1001;
    localparam logic [23:0] DZQ_RES  = 24'h000000;
    localparam logic [3:0]  DZQ_FL   = 4'b1001;
    localparam logic [23:0] DZR_RES  = 24'h000000;
    localparam logic [3:0]  DZR_FL   = 4'b1001;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unsigned_if #(.DATA_W(DW), .TGT_W(TW)) bus ();

    ex_muldiv_unsigned #(.DATA_W(DW), .TGT_W(TW)) dut (
        .iw_clk(clk),
        .iw_rst(rst),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full-width product, native / and %.
    function automatic void model_calc(input logic [1:0] op, input logic [23:0] src,
                                       input logic [23:0] tgt, output logic [23:0] res,
                                       output logic [3:0] fl, output bit fast);
        logic [47:0] p;
        bit c, v;
        p = 48'(tgt) * 48'(src);
        c = 0;
        v = 0;
        fast = 0;
        res = '0;
        case (op)
            2'd0: begin
                res = p[23:0];
                c = (p[47:24] != 0);
            end
            2'd1: res = p[47:24];
            default: begin
`ifdef MULDIV_DIV_EN
                if (src == 0) begin
                    fast = 1;
                    v = 1;
                    res = (op == 2'd2) ? 24'hFFFFFF : tgt;
                end else begin
                    res = (op == 2'd2) ? (tgt / src) : (tgt % src);
                end
`else
                fast = 1;
                v = 1;
                res = '0;
`endif
            end
        endcase
        fl = {v, c, res[23], (res == 0)};
    endfunction

    bit          m_busy, m_done;
    int          m_left;
    logic [23:0] m_res = '0, m_pres = '0;
    logic [3:0]  m_flags = '0, m_pflags = '0;
    logic [3:0]  m_tag = '0, m_ptag = '0;

    always @(posedge clk or posedge rst) begin
        logic [23:0] r;
        logic [3:0]  f;
        bit          fast;
        if (rst) begin
            m_busy  <= 0;
            m_done  <= 0;
            m_left  <= 0;
            m_res   <= '0;
            m_flags <= '0;
            m_tag   <= '0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                if (bus.iw_flush) begin
                    m_busy <= 0;
                end else if (m_left == 1) begin
                    m_busy  <= 0;
                    m_done  <= 1;
                    m_res   <= m_pres;
                    m_flags <= m_pflags;
                    m_tag   <= m_ptag;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.iw_start && !bus.iw_flush) begin
                model_calc(bus.iw_op, bus.iw_src, bus.iw_tgt, r, f, fast);
                if (fast) begin
                    m_done  <= 1;
                    m_res   <= r;
                    m_flags <= f;
                    m_tag   <= bus.iw_tgt_gp;
                end else begin
                    m_busy   <= 1;
                    m_left   <= DW;
                    m_pres   <= r;
                    m_pflags <= f;
                    m_ptag   <= bus.iw_tgt_gp;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_busy", 64'(bus.ow_busy), 64'(m_busy));
            chk("cyc_done", 64'(bus.ow_done), 64'(m_done));
            chk("cyc_result", 64'(bus.ow_result), 64'(m_res));
            chk("cyc_flags", 64'(bus.ow_flags), 64'(m_flags));
            chk("cyc_tag", 64'(bus.ow_tgt_gp), 64'(m_tag));
        end
    end

    task automatic drive(input logic [1:0] op, input logic [23:0] src, input logic [23:0] tgt,
                         input logic [3:0] tag);
        bus.iw_op = op;
        bus.iw_src = src;
        bus.iw_tgt = tgt;
        bus.iw_tgt_gp = tag;
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [23:0] src, input logic [23:0] tgt,
                         input logic [3:0] tag);
        drive(op, src, tgt, tag);
        bus.iw_start = 1'b1;
        @(posedge clk);
        #1 bus.iw_start = 1'b0;
    endtask

    // n = rising edges after the accept edge until done is seen; returns at that falling edge.
    task automatic wait_done(output int n);
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n <= 100) begin
            @(negedge clk);
            if (bus.ow_done === 1'b1) seen = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_100_cycles");
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [23:0] src,
                          input logic [23:0] tgt, input logic [3:0] tag, input int lat,
                          input logic [23:0] res, input logic [3:0] fl);
        int n;
        issue(op, src, tgt, tag);
        wait_done(n);
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_res"}, 64'(bus.ow_result), 64'(res));
        chk({nm, "_flags"}, 64'(bus.ow_flags), 64'(fl));
        chk({nm, "_tag"}, 64'(bus.ow_tgt_gp), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] r;
        logic [3:0]  f;
        bit          fast;
        int          n, dn;

        bus.iw_start = 0;
        bus.iw_flush = 0;
        drive(2'd0, '0, '0, '0);

        model_calc(2'd0, 24'h000100, 24'h001000, r, f, fast);
        chk("model_mul_lo", {36'(r), 4'(f), 24'(fast)}, {36'h100000, 4'h0, 24'h0});
        model_calc(2'd1, 24'hFFFFFF, 24'hFFFFFF, r, f, fast);
        chk("model_mul_hi", {36'(r), 4'(f), 24'(fast)}, {36'hFFFFFE, 4'h2, 24'h0});
        model_calc(2'd2, 24'h000000, 24'h123456, r, f, fast);
        chk("model_div0", {36'(r), 4'(f), 24'(fast)}, {36'(DZQ_RES), 4'(DZQ_FL), 24'h1});

        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_busy", 64'(bus.ow_busy), 64'd0);
        chk("rst_done", 64'(bus.ow_done), 64'd0);
        chk("rst_result", 64'(bus.ow_result), 64'd0);
        chk("rst_flags", 64'(bus.ow_flags), 64'd0);
        chk("rst_tag", 64'(bus.ow_tgt_gp), 64'd0);
        @(posedge clk);
        #1;

        run_op("mul_small", 2'd0, 24'h000100, 24'h001000, 4'h5, 24, 24'h100000, 4'b0000);
        run_op("mul_lo_max", 2'd0, 24'hFFFFFF, 24'hFFFFFF, 4'h3, 24, 24'h000001, 4'b0100);
        run_op("mul_hi_max", 2'd1, 24'hFFFFFF, 24'hFFFFFF, 4'h6, 24, 24'hFFFFFE, 4'b0010);
        run_op("divu", 2'd2, 24'h000007, 24'h000064, 4'h1, DIV_LAT, DIVU_RES, DIVU_FL);
        run_op("remu", 2'd3, 24'h000007, 24'h000064, 4'h2, DIV_LAT, REMU_RES, REMU_FL);
        run_op("divu_zero", 2'd2, 24'h000000, 24'h123456, 4'h4, 0, DZQ_RES, DZQ_FL);
        run_op("remu_zero", 2'd3, 24'h000000, 24'h123456, 4'hC, 0, DZR_RES, DZR_FL);

        // Flush five cycles in: no done, previous outputs stay.
        issue(2'd0, 24'h000010, 24'h000010, 4'h7);
        repeat (4) @(posedge clk);
        #1 bus.iw_flush = 1;
        @(posedge clk);
        #1 bus.iw_flush = 0;
        chk("flush_busy", 64'(bus.ow_busy), 64'd0);
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.ow_done === 1'b1) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        chk("flush_held_res", 64'(bus.ow_result), 64'(DZR_RES));
        chk("flush_held_tag", 64'(bus.ow_tgt_gp), 64'hC);
        @(posedge clk);
        #1;

        // Start while busy is ignored.
        issue(2'd0, 24'h000456, 24'h000123, 4'h9);
        repeat (3) @(posedge clk);
        #1 drive(2'd1, 24'hABCDEF, 24'h777777, 4'hE);
        bus.iw_start = 1;
        @(posedge clk);
        #1 bus.iw_start = 0;
        wait_done(n);
        chk("ign_lat", 64'(n + 4), 64'd24);
        chk("ign_res", 64'(bus.ow_result), 64'h04EDC2);
        chk("ign_tag", 64'(bus.ow_tgt_gp), 64'h9);
        @(posedge clk);
        #1;

        // Back-to-back: start held through the DONE cycle.
        drive(2'd0, 24'h000003, 24'h000002, 4'h1);
        bus.iw_start = 1;
        @(posedge clk);
        #1 drive(2'd1, 24'h000004, 24'h800000, 4'h2);
        wait_done(n);
        chk("b2b1_lat", 64'(n), 64'd24);
        chk("b2b1_res", 64'(bus.ow_result), 64'h000006);
        chk("b2b1_tag", 64'(bus.ow_tgt_gp), 64'h1);
        @(posedge clk);
        #1 bus.iw_start = 0;
        chk("b2b_busy", 64'(bus.ow_busy), 64'd1);
        wait_done(n);
        chk("b2b2_lat", 64'(n), 64'd24);
        chk("b2b2_res", 64'(bus.ow_result), 64'h000002);
        chk("b2b2_tag", 64'(bus.ow_tgt_gp), 64'h2);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-run clears everything without waiting for an edge.
        issue(2'd0, 24'hFFFFFF, 24'hFFFFFF, 4'hA);
        repeat (5) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_busy", 64'(bus.ow_busy), 64'd0);
        chk("arst_done", 64'(bus.ow_done), 64'd0);
        chk("arst_result", 64'(bus.ow_result), 64'd0);
        chk("arst_flags", 64'(bus.ow_flags), 64'd0);
        chk("arst_tag", 64'(bus.ow_tgt_gp), 64'd0);
        @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 3000; i++) begin
            bus.iw_start = ($urandom_range(0, 2) == 0);
            bus.iw_flush = ($urandom_range(0, 39) == 0);
            bus.iw_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       bus.iw_src = '0;
                1, 2:    bus.iw_src = 24'($urandom_range(1, 255));
                default: bus.iw_src = 24'($urandom);
            endcase
            bus.iw_tgt = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 255))
                                                     : 24'($urandom);
            bus.iw_tgt_gp = 4'($urandom);
            @(posedge clk);
            #1;
        end
        bus.iw_start = 0;
        bus.iw_flush = 0;
        repeat (30) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
